// File: rtl/mult9x9_stream.sv
// Streaming 9x9 multiplier. A two-stage valid/ready pipeline surrounds a purely combinational
// MULT9X9 core with all internal registers bypassed. Backpressure gates the clock enables of both stages.

module mult9x9_bypass (
    input  logic [8:0]  a_i,
    input  logic        sa_i,
    input  logic [8:0]  b_i,
    input  logic        sb_i,
    output logic [17:0] z_o
);
    logic [17:0] a_ext;
    logic [17:0] b_ext;

    // Each sign flag selects sign- or zero-extension. Every 9x9 product then fits in the low 18 bits.
    assign a_ext = sa_i ? {{9{a_i[8]}}, a_i} : {9'd0, a_i};
    assign b_ext = sb_i ? {{9{b_i[8]}}, b_i} : {9'd0, b_i};
    assign z_o   = a_ext * b_ext;
endmodule

module mult9x9_stream (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [8:0]  A,
    input  logic        SA,
    input  logic [8:0]  B,
    input  logic        SB,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [17:0] Z,
    output logic        ZS,
    output logic [15:0] COUNT
);
    logic        v1_q, v1_d;
    logic        v2_q, v2_d;
    logic [8:0]  ra_q, ra_d;
    logic [8:0]  rb_q, rb_d;
    logic        rsa_q, rsa_d;
    logic        rsb_q, rsb_d;
    logic [17:0] z_q, z_d;
    logic        zs_q, zs_d;
    logic [15:0] count_q, count_d;

    logic        accept;
    logic        adv2;
    logic        emit;
    logic [17:0] prod;

    // Stage 1 may refill in the same cycle it hands its beat to stage 2, so IN_READY looks through to OUT_READY.
    assign adv2     = v1_q & (~v2_q | OUT_READY);
    assign IN_READY = ~v1_q | adv2;
    assign accept   = IN_VALID & IN_READY;
    assign emit     = v2_q & OUT_READY;

    mult9x9_bypass u_mult (
        .a_i  (ra_q),
        .sa_i (rsa_q),
        .b_i  (rb_q),
        .sb_i (rsb_q),
        .z_o  (prod)
    );

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path through this block infers a latch.
        ra_d    = ra_q;
        rb_d    = rb_q;
        rsa_d   = rsa_q;
        rsb_d   = rsb_q;
        z_d     = z_q;
        zs_d    = zs_q;
        count_d = count_q;

        if (accept) begin
            ra_d  = A;
            rb_d  = B;
            rsa_d = SA;
            rsb_d = SB;
        end
        v1_d = accept ? 1'b1 : (adv2 ? 1'b0 : v1_q);

        if (adv2) begin
            z_d  = prod;
            zs_d = rsa_q | rsb_q;
        end
        v2_d = adv2 ? 1'b1 : (OUT_READY ? 1'b0 : v2_q);

        if (emit) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments, so all of them update together from pre-edge values.
        if (RST) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            ra_q    <= 9'd0;
            rb_q    <= 9'd0;
            rsa_q   <= 1'b0;
            rsb_q   <= 1'b0;
            z_q     <= 18'd0;
            zs_q    <= 1'b0;
            count_q <= 16'd0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rsa_q   <= rsa_d;
            rsb_q   <= rsb_d;
            z_q     <= z_d;
            zs_q    <= zs_d;
            count_q <= count_d;
        end
    end

    assign OUT_VALID = v2_q;
    assign Z         = z_q;
    assign ZS        = zs_q;
    assign COUNT     = count_q;
endmodule

// File: tb/tb_mult9x9_stream.sv
// Self-checking bench for mult9x9_stream. It combines a vector table, hand-written corner sequences and random traffic.
// An in-order scoreboard is filled on every accept and drained on every emit.

module tb_mult9x9_stream;
    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [8:0]  A;
    logic        SA;
    logic [8:0]  B;
    logic        SB;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [17:0] Z;
    logic        ZS;
    logic [15:0] COUNT;

    mult9x9_stream dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .SA        (SA),
        .B         (B),
        .SB        (SB),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Z         (Z),
        .ZS        (ZS),
        .COUNT     (COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [17:0] z;
        logic        zs;
        int          acc_cyc;
    } sb_t;

    typedef struct {
        logic [8:0]  a;
        logic        sa;
        logic [8:0]  b;
        logic        sb;
        logic [17:0] z;
        logic        zs;
    } vec_t;

    sb_t         exp_q[$];
    int          emit_cyc[$];
    vec_t        vecs[10];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_emit   = 0;
    int          last_lat = 0;
    logic [17:0] drv_z;
    logic        drv_zs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [17:0] ref_prod(input logic [8:0] a, input logic sa,
                                             input logic [8:0] b, input logic sb);
        int av;
        int bv;
        int p;
        av = int'(a);
        bv = int'(b);
        if (sa && a[8]) av = av - 512;
        if (sb && b[8]) bv = bv - 512;
        p = av * bv;
        return p[17:0];
    endfunction

    // Outputs and handshakes are sampled on the falling edge, away from the active edge.
    always @(negedge CLK) begin : monitor
        sb_t e;
        cyc++;
        if (RST) begin
            exp_q.delete();
            n_emit = 0;
        end else begin
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_emit_pending", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_z", 32'(Z), 32'(e.z));
                    check("sb_zs", 32'(ZS), 32'(e.zs));
                    last_lat = cyc - e.acc_cyc;
                end
                emit_cyc.push_back(cyc);
                n_emit++;
            end
            if (IN_VALID && IN_READY) begin
                e.z       = drv_z;
                e.zs      = drv_zs;
                e.acc_cyc = cyc;
                exp_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int n);
        RST      = 1'b1;
        IN_VALID = 1'b0;
        repeat (n) step();
        RST = 1'b0;
    endtask

    task automatic set_beat(input logic [8:0] a, input logic sa, input logic [8:0] b,
                            input logic sb, input logic [17:0] z, input logic zs);
        A        = a;
        SA       = sa;
        B        = b;
        SB       = sb;
        drv_z    = z;
        drv_zs   = zs;
        IN_VALID = 1'b1;
    endtask

    task automatic send(input logic [8:0] a, input logic sa, input logic [8:0] b,
                        input logic sb, input logic [17:0] z, input logic zs);
        bit acc = 1'b0;
        set_beat(a, sa, b, sb, z, zs);
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge CLK);
            acc = IN_READY;
            step();
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        IN_VALID = 1'b0;
    endtask

    task automatic send_vec(input int i);
        send(vecs[i].a, vecs[i].sa, vecs[i].b, vecs[i].sb, vecs[i].z, vecs[i].zs);
    endtask

    task automatic pick_random(output logic [8:0] a, output logic sa,
                               output logic [8:0] b, output logic sb);
        a  = 9'($urandom_range(0, 511));
        b  = 9'($urandom_range(0, 511));
        sa = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1));
    endtask

    task automatic send_random();
        logic [8:0] a, b;
        logic       sa, sb;
        pick_random(a, sa, b, sb);
        send(a, sa, b, sb, ref_prod(a, sa, b, sb), sa | sb);
    endtask

    task automatic drain();
        bit done = 1'b0;
        OUT_READY = 1'b1;
        IN_VALID  = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (exp_q.size() == 0 && OUT_VALID === 1'b0) done = 1'b1;
            else step();
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          sent;
        bit          acc;
        logic [8:0]  ra, rb;
        logic        rsa, rsb;

        vecs[0] = '{9'h1FF, 1'b0, 9'h1FF, 1'b0, 18'h3FC01, 1'b0};
        vecs[1] = '{9'h100, 1'b1, 9'h100, 1'b1, 18'h10000, 1'b1};
        vecs[2] = '{9'h100, 1'b1, 9'h1FF, 1'b0, 18'h20100, 1'b1};
        vecs[3] = '{9'h003, 1'b0, 9'h1FF, 1'b1, 18'h3FFFD, 1'b1};
        vecs[4] = '{9'h1FF, 1'b0, 9'h1FF, 1'b1, 18'h3FE01, 1'b1};
        vecs[5] = '{9'h1FF, 1'b1, 9'h1FF, 1'b1, 18'h00001, 1'b1};
        vecs[6] = '{9'h000, 1'b0, 9'h155, 1'b1, 18'h00000, 1'b1};
        vecs[7] = '{9'h100, 1'b0, 9'h100, 1'b0, 18'h10000, 1'b0};
        vecs[8] = '{9'd100, 1'b0, 9'd200, 1'b0, 18'h04E20, 1'b0};
        vecs[9] = '{9'h1F6, 1'b1, 9'd7,   1'b0, 18'h3FFBA, 1'b1};

        // Reset held with a beat offered: nothing may be accepted.
        RST       = 1'b1;
        OUT_READY = 1'b1;
        set_beat(9'd5, 1'b0, 9'd5, 1'b0, 18'd25, 1'b0);
        repeat (3) begin
            @(posedge CLK);
            @(negedge CLK);
            check("rst_in_ready", 32'(IN_READY), 32'd1);
        end
        step();
        RST      = 1'b0;
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_z", 32'(Z), 32'd0);
        check("rst_zs", 32'(ZS), 32'd0);
        check("rst_in_ready_after", 32'(IN_READY), 32'd1);
        repeat (2) step();
        check("rst_no_accept", 32'(OUT_VALID), 32'd0);

        // Unsigned maximum with latency measurement.
        do_reset(1);
        send_vec(0);
        drain();
        check("umax_latency", 32'(last_lat), 32'd2);
        check("umax_z_hold", 32'(Z), 32'h3FC01);
        check("umax_zs", 32'(ZS), 32'd0);
        check("umax_count", 32'(COUNT), 32'd1);

        // Sign combinations back-to-back must emit on consecutive cycles.
        do_reset(1);
        emit_cyc.delete();
        for (int i = 1; i <= 3; i++) send_vec(i);
        drain();
        check("sign_emits", 32'(emit_cyc.size()), 32'd3);
        if (emit_cyc.size() == 3) begin
            check("sign_gap0", 32'(emit_cyc[1] - emit_cyc[0]), 32'd1);
            check("sign_gap1", 32'(emit_cyc[2] - emit_cyc[1]), 32'd1);
        end
        check("sign_count", 32'(COUNT), 32'd3);

        // Whole vector table streamed back-to-back.
        do_reset(1);
        for (int i = 0; i < 10; i++) send_vec(i);
        drain();
        check("table_count", 32'(COUNT), 32'd10);

        // Backpressure: capacity is two beats, and the output holds while stalled.
        do_reset(1);
        OUT_READY = 1'b1;
        send(9'd1, 1'b0, 9'd1, 1'b0, 18'd1, 1'b0);
        OUT_READY = 1'b0;
        send(9'd2, 1'b0, 9'd2, 1'b0, 18'd4, 1'b0);
        set_beat(9'd3, 1'b0, 9'd3, 1'b0, 18'd9, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("bp_in_ready", 32'(IN_READY), 32'd0);
            check("bp_out_valid", 32'(OUT_VALID), 32'd1);
            check("bp_z_hold", 32'(Z), 32'd1);
        end
        step();
        OUT_READY = 1'b1;
        send(9'd3, 1'b0, 9'd3, 1'b0, 18'd9, 1'b0);
        drain();
        check("bp_emits", 32'(n_emit), 32'd3);
        check("bp_count", 32'(COUNT), 32'd3);

        // Random traffic with random valid and ready.
        do_reset(1);
        sent = 0;
        for (int it = 0; it < 60000 && sent < 10000; it++) begin
            if (!IN_VALID && $urandom_range(0, 3) != 0) begin
                pick_random(ra, rsa, rb, rsb);
                set_beat(ra, rsa, rb, rsb, ref_prod(ra, rsa, rb, rsb), rsa | rsb);
            end
            OUT_READY = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            acc = IN_VALID && IN_READY;
            if (acc) sent++;
            step();
            if (acc) IN_VALID = 1'b0;
        end
        check("rand_sent", 32'(sent), 32'd10000);
        drain();
        check("rand_emits", 32'(n_emit), 32'd10000);
        check("rand_count", 32'(COUNT), 32'd10000);

        // Run the counter up to 65535, then wrap it with one more emit.
        for (int i = 0; i < 55535; i++) send_random();
        drain();
        check("wrap_count_max", 32'(COUNT), 32'd65535);
        send_random();
        drain();
        check("wrap_count_zero", 32'(COUNT), 32'd0);

        // Reset with both stages full discards every in-flight beat.
        OUT_READY = 1'b0;
        send(9'd10, 1'b0, 9'd10, 1'b0, 18'd100, 1'b0);
        send(9'd11, 1'b0, 9'd11, 1'b0, 18'd121, 1'b0);
        set_beat(9'd12, 1'b0, 9'd12, 1'b0, 18'd144, 1'b0);
        @(negedge CLK);
        check("full_in_ready", 32'(IN_READY), 32'd0);
        check("full_out_valid", 32'(OUT_VALID), 32'd1);
        step();
        RST = 1'b1;
        step();
        RST       = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        @(negedge CLK);
        check("midrst_out_valid", 32'(OUT_VALID), 32'd0);
        check("midrst_in_ready", 32'(IN_READY), 32'd1);
        check("midrst_count", 32'(COUNT), 32'd0);
        repeat (5) step();
        check("midrst_no_stale", 32'(OUT_VALID), 32'd0);
        check("midrst_emits", 32'(n_emit), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mult9x9_stream.md
# mult9x9_stream

Streaming 9x9 multiplier that puts a valid/ready handshake around one MULT9X9 primitive instantiated with REGINPUTA, REGINPUTB and REGOUTPUT all set to "BYPASS". The block's own input and output pipeline registers carry clock enables driven by backpressure. This exercises the DSP-FF absorption pass from the consumer side, with enable-gated registers on both ends of the primitive. It also serves as the cycle-accurate reference for equivalence checks against the packed result.

## Interface
- No parameters; operand and product widths are fixed at 9, 9 and 18 by the primitive.
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  operand beat present.
- IN_READY  output  1  block accepts the beat this cycle.
- A  input  9  operand A.
- SA  input  1  A is two's-complement when 1, unsigned when 0.
- B  input  9  operand B.
- SB  input  1  B is two's-complement when 1, unsigned when 0.
- OUT_VALID  output  1  product beat present.
- OUT_READY  input  1  downstream accepts the product.
- Z  output  18  product.
- ZS  output  1  product is signed, equal to SA|SB of the originating beat.
- COUNT  output  16  number of completed output handshakes; wraps at 65535 -> 0.

## Operation
- Accept: IN_VALID & IN_READY. Emit: OUT_VALID & OUT_READY.
- Stage 1 registers: ra, rb, rsa, rsb and v1. They load on accept.
- MULT9X9 is driven combinationally from stage 1: A=ra, B=rb, SIGNEDA=rsa, SIGNEDB=rsb.
- Stage 2 registers: Z, ZS and v2 (OUT_VALID). They load the primitive output when stage 1 advances.
- Advance rules:
  - adv2 = v1 & (!v2 | OUT_READY).
  - IN_READY = !v1 | adv2, which is combinational from OUT_READY.
  - v1_next = accept ? 1 : (adv2 ? 0 : v1).
  - v2_next = adv2 ? 1 : (OUT_READY ? 0 : v2).
- Stage 1 data registers are enabled only by accept. Stage 2 data registers are enabled only by adv2. Both hold value otherwise, so no beat is dropped or duplicated under backpressure.
- Arithmetic:
  - Each operand is extended to 18 bits, sign-extended if its sign flag is 1, otherwise zero-extended.
  - Z is the low 18 bits of the product.
  - Every 9x9 result fits without overflow. Extremes: 511*511=261121 (0x3FC01); -256*-256=65536 (0x10000); -256*511=-130816 (0x20100).
- COUNT increments by 1 on each emit and wraps.
- Reset:
  - v1, v2, OUT_VALID, COUNT, Z, ZS, ra, rb, rsa, rsb all clear to 0.
  - IN_READY is 1 during and after reset because v1=0.
  - Reset mid-stream discards every in-flight beat.
  - A beat presented while RST is high is not accepted.

## Timing
- Latency is 2 cycles: a beat accepted at edge N appears on Z/OUT_VALID after edge N+1, if OUT_READY was high or v2 was clear.
- Throughput is 1 beat per cycle while OUT_READY=1.
- Capacity is 2 beats, one per stage. With OUT_READY=0 and both stages full, IN_READY=0.
- Simultaneous emit and adv2 in one cycle: stage 2 reloads and OUT_VALID stays 1.
- Simultaneous accept and adv2 in one cycle: stage 1 reloads and v1 stays 1.
- Z, ZS and OUT_VALID hold stable while OUT_VALID=1 and OUT_READY=0.

## Test plan
- Reset behaviour: hold RST for 3 cycles with IN_VALID=1 -> no accept; then OUT_VALID=0, COUNT=0, Z=0, IN_READY=1.
- Unsigned maximum: A=511, B=511, SA=SB=0, OUT_READY=1 -> exactly 2 cycles after accept, Z=0x3FC01, ZS=0, COUNT=1.
- Sign combinations: stream (-256,-256,1,1), (-256,511,1,0), (3,-1,0,1) back-to-back -> Z = 0x10000, 0x20100, 0x3FFFD on 3 consecutive cycles, ZS=1 each, COUNT=3.
- Backpressure: stream 1*1, 2*2, 3*3 with OUT_READY=0 from the second cycle ->
  - IN_READY drops after 2 accepts and Z holds 1.
  - Release OUT_READY -> outputs 1, 4, 9 in order, none lost or duplicated.
- Random traffic: 10,000 random beats with random IN_VALID and OUT_READY -> every product matches the reference model in order; COUNT = 10000 mod 65536.
- Reset mid-stream and counter wrap:
  - Pulse RST with both stages full -> OUT_VALID=0 next cycle, and no stale beat appears afterwards.
  - Preload 65535 emits -> COUNT wraps to 0 on the next emit.
